ex_muldiv_ctrl: RTL and testbench

Execute-stage sequencer for the MIPS iterative multiply/divide unit and the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs a one-bit-per-cycle shift-add multiply or restoring divide over the ALU operand values. It stalls the pipeline while a HI/LO consumer or a new mul/div op reaches EX before the result is ready. It also handles flush abort and divide-by-zero.

---
 rtl/ex_muldiv_ctrl_if.sv | 28 ++
 rtl/ex_muldiv_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_ctrl_if.sv
// Handshake and result bundle between the EX stage and the mul/div/HI-LO unit.
// The EX stage (master) presents the op and operands; the unit (slave) returns
// the HI/LO contents, its busy/stall status and the divide-by-zero pulse.
interface ex_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       EX_md_op;
    logic             EX_md_start;
    logic             EX_md_rd;
    logic             EX_flush;
    logic [WIDTH-1:0] EX_rs_val;
    logic [WIDTH-1:0] EX_rt_val;
    logic [WIDTH-1:0] EX_hi;
    logic [WIDTH-1:0] EX_lo;
    logic             EX_md_busy;
    logic             EX_md_stall;
    logic             EX_div_zero;

    modport master (
        output EX_md_op, EX_md_start, EX_md_rd, EX_flush, EX_rs_val, EX_rt_val,
        input  EX_hi, EX_lo, EX_md_busy, EX_md_stall, EX_div_zero
    );

    modport slave (
        input  EX_md_op, EX_md_start, EX_md_rd, EX_flush, EX_rs_val, EX_rt_val,
        output EX_hi, EX_lo, EX_md_busy, EX_md_stall, EX_div_zero
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Execute-stage sequencer for the iterative multiply/divide unit and HI/LO.
// Multiply is one-bit-per-cycle shift-add on operand magnitudes, divide is
// restoring division; signs are reapplied in a single FIX cycle at the end.
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    ex_muldiv_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [CW-1:0]      r_count;
    logic               r_isDiv;
    logic               r_negQ;
    logic               r_negR;
    logic               r_busy;
    logic               r_divZero;

    logic               w_isSigned;
    logic               w_rsNeg;
    logic               w_rtNeg;
    logic [WIDTH-1:0]   w_rsMag;
    logic [WIDTH-1:0]   w_rtMag;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_remShift;
    logic               w_trialOk;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_divNext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Operand magnitudes: only the signed ops fold negative inputs to abs value.
    assign w_isSigned = (bus.EX_md_op == OP_MULT) || (bus.EX_md_op == OP_DIV);
    assign w_rsNeg    = w_isSigned & bus.EX_rs_val[WIDTH-1];
    assign w_rtNeg    = w_isSigned & bus.EX_rt_val[WIDTH-1];
    assign w_rsMag    = w_rsNeg ? (-bus.EX_rs_val) : bus.EX_rs_val;
    assign w_rtMag    = w_rtNeg ? (-bus.EX_rt_val) : bus.EX_rt_val;

    // One multiply step: multiplier sits in the low half and shifts out; the
    // carry of the upper-half add shifts back into the top of the accumulator.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mulNext = r_acc[0] ? {w_mulSum, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};

    // One restoring-divide step: the shifted remainder needs WIDTH+1 bits, but
    // a successful difference is always below the divisor so WIDTH bits suffice.
    assign w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trialOk  = (w_remShift >= {1'b0, r_opnd});
    assign w_diff     = w_remShift[WIDTH-1:0] - r_opnd;
    assign w_divNext  = w_trialOk ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                                  : {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // Sign fix-up for the FIX cycle; unsigned ops never set the negate flags.
    assign w_prod = r_negQ ? (-r_acc) : r_acc;
    assign w_quot = r_negQ ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem  = r_negR ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

    assign bus.EX_hi       = r_hi;
    assign bus.EX_lo       = r_lo;
    assign bus.EX_md_busy  = r_busy;
    assign bus.EX_div_zero = r_divZero;
    assign bus.EX_md_stall = r_busy & (bus.EX_md_rd | bus.EX_md_start);

    // Sequencer: accepts ops in IDLE, iterates WIDTH times, commits in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_busy    <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            r_divZero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.EX_md_start && !bus.EX_flush) begin
                        case (bus.EX_md_op)
                            OP_MULT, OP_MULTU: begin
                                r_acc   <= {{WIDTH{1'b0}}, w_rtMag};
                                r_opnd  <= w_rsMag;
                                r_negQ  <= w_rsNeg ^ w_rtNeg;
                                r_negR  <= 1'b0;
                                r_isDiv <= 1'b0;
                                r_count <= CW'(WIDTH);
                                r_busy  <= 1'b1;
                                r_state <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (bus.EX_rt_val == '0) begin
                                    r_divZero <= 1'b1;
                                end else begin
                                    r_acc   <= {{WIDTH{1'b0}}, w_rsMag};
                                    r_opnd  <= w_rtMag;
                                    r_negQ  <= w_rsNeg ^ w_rtNeg;
                                    r_negR  <= w_rsNeg;
                                    r_isDiv <= 1'b1;
                                    r_count <= CW'(WIDTH);
                                    r_busy  <= 1'b1;
                                    r_state <= S_DIV;
                                end
                            end
                            OP_MTHI: r_hi <= bus.EX_rs_val;
                            OP_MTLO: r_lo <= bus.EX_rs_val;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (bus.EX_flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc   <= (r_state == S_MUL) ? w_mulNext : w_divNext;
                        r_count <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!bus.EX_flush) begin
                        if (r_isDiv) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: expected HI/LO pairs come from a
// behavioural model, are queued when an op is driven and popped on completion.
module tb_ex_muldiv_ctrl;
    localparam int WIDTH = 32;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic clk = 1'b0;
    logic rst_n;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    ex_muldiv_ctrl_if #(.WIDTH(WIDTH)) bus ();

    ex_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checkCount = 0;
    int          errorCount = 0;
    logic [63:0] expQueue[$];
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference arithmetic done in 64-bit integers, independent of the datapath.
    function automatic logic [63:0] modelOp(input logic [2:0] op, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [31:0] hi,
                                            input logic [31:0] lo);
        longint      a;
        longint      b;
        logic [63:0] q;
        logic [63:0] rm;
        logic [63:0] r;
        r = {hi, lo};
        case (op)
            OP_MULTU: r = {32'h0, rs} * {32'h0, rt};
            OP_MULT: begin
                a = $signed(rs);
                b = $signed(rt);
                r = a * b;
            end
            OP_DIVU: if (rt != 0) r = {rs % rt, rs / rt};
            OP_DIV: if (rt != 0) begin
                a  = $signed(rs);
                b  = $signed(rt);
                q  = a / b;
                rm = a % b;
                r  = {rm[31:0], q[31:0]};
            end
            OP_MTHI: r = {rs, lo};
            OP_MTLO: r = {hi, rs};
            default: ;
        endcase
        return r;
    endfunction

    // Present one op for one cycle; committed ops queue their model result.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, input bit flushIt, input bit commits);
        logic [63:0] exp;
        @(negedge clk);
        bus.EX_md_op    = op;
        bus.EX_md_start = 1'b1;
        bus.EX_rs_val   = rs;
        bus.EX_rt_val   = rt;
        bus.EX_flush    = flushIt;
        if (commits) begin
            exp = modelOp(op, rs, rt, modelHi, modelLo);
            expQueue.push_back(exp);
            {modelHi, modelLo} = exp;
        end
        @(negedge clk);
        bus.EX_md_start = 1'b0;
        bus.EX_md_op    = OP_NONE;
        bus.EX_flush    = 1'b0;
    endtask

    task automatic popCompare(input string tag);
        logic [63:0] exp;
        if (expQueue.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL %s scoreboard empty", tag);
        end else begin
            exp = expQueue.pop_front();
            checkOutput(tag, {bus.EX_hi, bus.EX_lo}, exp);
        end
    endtask

    // Follow an iterative op to completion, optionally raising MFHI/MFLO after rdDelay cycles.
    task automatic waitDone(input string tag, input int rdDelay);
        int busyCycles = 0;
        int stallBad   = 0;
        while (bus.EX_md_busy === 1'b1 && busyCycles < 100) begin
            if (rdDelay >= 0 && busyCycles >= rdDelay) bus.EX_md_rd = 1'b1;
            #1;
            if (bus.EX_md_stall !== (rdDelay >= 0 && busyCycles >= rdDelay)) stallBad++;
            busyCycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_busyCycles"}, busyCycles, 33);
        checkOutput({tag, "_stallWhileBusy"}, stallBad, 0);
        checkOutput({tag, "_stallAfter"}, bus.EX_md_stall, 0);
        popCompare({tag, "_hilo"});
        bus.EX_md_rd = 1'b0;
    endtask

    initial begin
        int dzHigh;
        int busyHigh;
        logic [31:0] rs;
        logic [31:0] rt;

        rst_n           = 1'b0;
        bus.EX_md_op    = OP_NONE;
        bus.EX_md_start = 1'b0;
        bus.EX_md_rd    = 1'b0;
        bus.EX_flush    = 1'b0;
        bus.EX_rs_val   = '0;
        bus.EX_rt_val   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", bus.EX_hi, 0);
        checkOutput("reset_lo", bus.EX_lo, 0);
        checkOutput("reset_busy", bus.EX_md_busy, 0);
        checkOutput("reset_stall", bus.EX_md_stall, 0);
        checkOutput("reset_divzero", bus.EX_div_zero, 0);
        rst_n = 1'b1;

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1);
        waitDone("multu_max_x2", -1);
        checkOutput("multu_const", {bus.EX_hi, bus.EX_lo}, 64'h0000_0001_FFFF_FFFE);

        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'h7, 1'b0, 1'b1);
        waitDone("mult_neg3x7_mfhi", 4);
        checkOutput("mult_const", {bus.EX_hi, bus.EX_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
        waitDone("divu_100_7", -1);
        checkOutput("divu_const", {bus.EX_hi, bus.EX_lo}, {32'd2, 32'd14});

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        waitDone("div_neg7_2", -1);
        checkOutput("div_const", {bus.EX_hi, bus.EX_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        waitDone("div_minint_neg1", 3);
        checkOutput("div_corner_const", {bus.EX_hi, bus.EX_lo}, 64'h0000_0000_8000_0000);

        applyStimulus(OP_MTHI, 32'h1234, 32'h0, 1'b0, 1'b1);
        checkOutput("mthi_busy", bus.EX_md_busy, 0);
        popCompare("mthi_hilo");
        applyStimulus(OP_MTLO, 32'h5678, 32'h0, 1'b0, 1'b1);
        checkOutput("mtlo_busy", bus.EX_md_busy, 0);
        popCompare("mtlo_hilo");

        applyStimulus(OP_DIV, 32'd55, 32'd0, 1'b0, 1'b1);
        dzHigh   = 0;
        busyHigh = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.EX_div_zero === 1'b1) dzHigh++;
            if (bus.EX_md_busy !== 1'b0) busyHigh++;
            @(negedge clk);
        end
        checkOutput("divzero_pulse_width", dzHigh, 1);
        checkOutput("divzero_busy", busyHigh, 0);
        popCompare("divzero_hilo");

        applyStimulus(OP_MULT, 32'd12345, 32'd678, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        checkOutput("flush_pre_busy", bus.EX_md_busy, 1);
        bus.EX_flush = 1'b1;
        @(negedge clk);
        bus.EX_flush = 1'b0;
        checkOutput("flush_busy", bus.EX_md_busy, 0);
        repeat (40) @(negedge clk);
        checkOutput("flush_hilo_kept", {bus.EX_hi, bus.EX_lo}, {modelHi, modelLo});

        applyStimulus(OP_MTLO, 32'hDEAD, 32'h0, 1'b1, 1'b0);
        checkOutput("flush_mtlo_hilo", {bus.EX_hi, bus.EX_lo}, {modelHi, modelLo});
        applyStimulus(OP_DIV, 32'd9, 32'd0, 1'b1, 1'b0);
        checkOutput("flush_divzero", bus.EX_div_zero, 0);

        applyStimulus(OP_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        checkOutput("reset_mid_prebusy", bus.EX_md_busy, 1);
        rst_n = 1'b0;
        #1;
        modelHi = '0;
        modelLo = '0;
        checkOutput("reset_mid_hilo", {bus.EX_hi, bus.EX_lo}, 64'h0);
        checkOutput("reset_mid_busy", bus.EX_md_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b1);
        waitDone("multu_3x5", -1);
        checkOutput("multu_3x5_const", {bus.EX_hi, bus.EX_lo}, 64'd15);

        for (int i = 0; i < 4; i++) begin
            rs = $urandom;
            rt = $urandom | 32'h1;
            applyStimulus(OP_MULT + 3'(i), rs, rt, 1'b0, 1'b1);
            waitDone($sformatf("rand_op%0d", i + 1), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
